pic_bus_bridge: RTL and testbench

Bus-side front end for the PIC core wrapper: accepts CPU load/store requests on a valid/ready bus and drives the wrapper's register port (`address`, `data_in`, `wen`, `ren`, `data_out`, `ready`) with correctly held strobes. Writes are posted through a small FIFO so the CPU does not stall on slow PIC-side accepts. Reads are strictly ordered behind all posted writes. The block sits directly upstream of the PIC wrapper, between the SoC bus decoder and the wrapper.

---
 rtl/pic_bridge_pkg.sv | 15 +
 rtl/pic_bridge_fifo.sv | 51 +++++
 rtl/pic_bus_bridge.sv | 176 +++++++++++++++++
 tb/tb_pic_bus_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_bridge_pkg.sv
// Shared types for the PIC bus bridge.
// FSM state encoding and the data returned on a read timeout.
package pic_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [31:0] TMO_RDATA = 32'hFFFF_FFFF;
  localparam int unsigned TMO_MIN_W = 8;

endpackage

// File: rtl/pic_bridge_fifo.sv
// Synchronous posted-write FIFO for the PIC bus bridge.
// Depth must be a power of two so the pointers wrap naturally.
module pic_bridge_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/pic_bus_bridge.sv
// CPU valid/ready bus to PIC wrapper register port, posted writes.
// Define PIC_BRIDGE_TIMEOUT_EN to abort strobes after TIMEOUT_CYCLES.
module pic_bus_bridge
  import pic_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] pic_address,
  output logic [DATA_W-1:0] pic_data_in,
  output logic              pic_wen,
  output logic              pic_ren,
  input  logic [DATA_W-1:0] pic_data_out,
  input  logic              pic_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_wen, w_wen_nxt;
  logic              r_ren, w_ren_nxt;
  logic              r_rvalid, w_rvalid_nxt;
  logic              r_err, w_err_nxt;
  logic              w_wr_acc, w_rd_acc;
  logic              w_pop, w_full, w_empty;
  logic              w_tmo_hit;
  logic [CNT_W-1:0]  w_count;
  logic [ENT_W-1:0]  w_fifo_dout;

  // Reads wait for a drained FIFO so they never pass a posted write.
  assign w_wr_acc  = reset & cpu_valid & cpu_we & ~w_full;
  assign w_rd_acc  = reset & cpu_valid & ~cpu_we
                   & (w_count == '0) & (r_state == S_IDLE);
  assign cpu_ready = w_wr_acc | w_rd_acc;

  pic_bridge_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_wr_acc),
    .i_din   ({cpu_addr, cpu_wdata}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

`ifdef PIC_BRIDGE_TIMEOUT_EN
  localparam int unsigned TMO_LOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TMO_W   =
    (TMO_LOG > TMO_MIN_W) ? TMO_LOG : TMO_MIN_W;

  logic [TMO_W-1:0] r_tmo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state == S_WR || r_state == S_RD) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_wen_nxt    = 1'b0;
    w_ren_nxt    = 1'b0;
    w_rvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_pop        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_addr_nxt  = w_fifo_dout[ENT_W-1 -: ADDR_W];
          w_wdata_nxt = w_fifo_dout[DATA_W-1:0];
          w_wen_nxt   = 1'b1;
          w_state_nxt = S_WR;
        end else if (w_rd_acc) begin
          w_addr_nxt  = cpu_addr;
          w_ren_nxt   = 1'b1;
          w_state_nxt = S_RD;
        end
      end
      S_WR: begin
        if (pic_ready) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wen_nxt = 1'b1;
        end
      end
      S_RD: begin
        if (pic_ready) begin
          w_rdata_nxt  = pic_data_out;
          w_rvalid_nxt = 1'b1;
          w_state_nxt  = S_RESP;
        end else if (w_tmo_hit) begin
          w_rdata_nxt  = DATA_W'(TMO_RDATA);
          w_rvalid_nxt = 1'b1;
          w_err_nxt    = 1'b1;
          w_state_nxt  = S_RESP;
        end else begin
          w_ren_nxt = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_wen    <= 1'b0;
      r_ren    <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_wen    <= w_wen_nxt;
      r_ren    <= w_ren_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign pic_address = r_addr;
  assign pic_data_in = r_wdata;
  assign pic_wen     = r_wen;
  assign pic_ren     = r_ren;
  assign cpu_rdata   = r_rdata;
  assign cpu_rvalid  = r_rvalid;
  assign cpu_err     = r_err;

endmodule

// File: tb/tb_pic_bus_bridge.sv
// Directed bench for pic_bus_bridge with write/read scoreboards.
// Honours PIC_BRIDGE_TIMEOUT_EN for the stuck-ready read case.
module tb_pic_bus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_err;
  logic [15:0] pic_address;
  logic [31:0] pic_data_in;
  logic        pic_wen;
  logic        pic_ren;
  logic [31:0] pic_data_out;
  logic        pic_ready;

  int n_pass = 0;
  int n_tot = 0;
  int n_wr_done = 0;
  int w, cnt, stall_bad, n0;

  logic [47:0] wq[$];
  logic [32:0] rq[$];

  pic_bus_bridge #(
    .ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_valid    (cpu_valid),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ready    (cpu_ready),
    .cpu_rdata    (cpu_rdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_err      (cpu_err),
    .pic_address  (pic_address),
    .pic_data_in  (pic_data_in),
    .pic_wen      (pic_wen),
    .pic_ren      (pic_ren),
    .pic_data_out (pic_data_out),
    .pic_ready    (pic_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_req(input logic [15:0] a, input logic [31:0] d,
                        output int waits);
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    waits     = 0;
    #1;
    while (!cpu_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk("wr_accept", cpu_ready, 1);
    if (cpu_ready) wq.push_back({a, d});
    tick();
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic rd_req(input logic [15:0] a, output int waits);
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = a;
    waits     = 0;
    #1;
    while (!cpu_ready && waits < 50) begin
      tick();
      waits++;
    end
    chk("rd_accept", cpu_ready, 1);
    tick();
    cpu_valid = 1'b0;
  endtask

  // PIC-side and response-side monitor
  always @(negedge clk) begin
    logic [47:0] ew;
    logic [32:0] er;
    if (pic_wen | pic_ren) chk("strobe_excl", pic_wen & pic_ren, 0);
    if (pic_wen && pic_ready) begin
      n_wr_done++;
      chk("wq_avail", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        ew = wq.pop_front();
        chk("pic_wr", {pic_address, pic_data_in}, ew);
      end
    end
    if (cpu_rvalid) begin
      chk("rq_avail", rq.size() > 0, 1);
      if (rq.size() > 0) begin
        er = rq.pop_front();
        chk("cpu_rd", {cpu_err, cpu_rdata}, er);
      end
    end
  end

  initial begin
    reset        = 1'b0;
    cpu_valid    = 1'b1;
    cpu_we       = 1'b0;
    cpu_addr     = 16'h0008;
    cpu_wdata    = '0;
    pic_ready    = 1'b0;
    pic_data_out = '0;
    repeat (3) tick();
    chk("rst_ready_rd", cpu_ready, 0);
    chk("rst_flags", {cpu_rvalid, cpu_err, pic_wen, pic_ren}, 0);
    chk("rst_pic", {pic_address, pic_data_in}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    cpu_we = 1'b1;
    #1;
    chk("rst_ready_wr", cpu_ready, 0);
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // single posted write, wrapper always ready
    pic_ready = 1'b1;
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0004;
    cpu_wdata = 32'h0000_00A5;
    #1;
    chk("w1_ready", cpu_ready, 1);
    wq.push_back({16'h0004, 32'h0000_00A5});
    tick();
    cpu_valid = 1'b0;
    cpu_we    = 1'b0;
    chk("w1_n1_wen", pic_wen, 0);
    tick();
    chk("w1_n2_wen", pic_wen, 1);
    chk("w1_n2_bus", {pic_address, pic_data_in},
        {16'h0004, 32'h0000_00A5});
    tick();
    chk("w1_n3_wen", pic_wen, 0);
    tick();

    // one write held in WR, then five more: four fill, fifth stalls
    pic_ready = 1'b0;
    wr_req(16'h0010, 32'h11, w);
    tick();
    chk("pre_wen", pic_wen, 1);
    for (int i = 0; i < 4; i++) begin
      wr_req(16'h0014 + 16'(4 * i), 32'h20 + 32'(i), w);
      chk("fill_nowait", w, 0);
    end
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h0024;
    cpu_wdata = 32'h30;
    stall_bad = 0;
    repeat (5) begin
      #1;
      if (cpu_ready) stall_bad++;
      tick();
    end
    chk("full_stall", stall_bad, 0);
    chk("full_wen_held", pic_wen, 1);
    pic_ready = 1'b1;
    wr_req(16'h0024, 32'h30, w);
    chk("full_release_wait", w, 2);
    w = 0;
    while (wq.size() != 0 && w < 100) begin
      tick();
      w++;
    end
    chk("drain_done", wq.size(), 0);
    chk("wr_count", n_wr_done, 7);
    repeat (2) tick();

    // read ordered behind two posted writes
    pic_data_out = 32'h1234_5678;
    wr_req(16'h0030, 32'hAAAA_0001, w);
    wr_req(16'h0034, 32'hAAAA_0002, w);
    rd_req(16'h0008, w);
    chk("rd_order_wait", w, 3);
    chk("rd_after_writes", n_wr_done, 9);
    rq.push_back({1'b0, 32'h1234_5678});
    chk("rd_strobe", {pic_wen, pic_ren, pic_address},
        {1'b0, 1'b1, 16'h0008});
    tick();
    chk("rd_rvalid", {cpu_rvalid, cpu_rdata}, {1'b1, 32'h1234_5678});
    chk("rd_ren_drop", pic_ren, 0);
    tick();
    chk("rd_rvalid_pulse", cpu_rvalid, 0);
    tick();

    // read with wrapper never ready
    pic_ready    = 1'b0;
    pic_data_out = 32'hCAFE_F00D;
    rd_req(16'h000C, w);
    chk("rd2_wait", w, 0);
`ifdef PIC_BRIDGE_TIMEOUT_EN
    rq.push_back({1'b1, 32'hFFFF_FFFF});
    cnt = 0;
    w = 0;
    while (!cpu_rvalid && w < 400) begin
      if (pic_ren) cnt++;
      tick();
      w++;
    end
    chk("tmo_ren_cycles", cnt, 255);
    chk("tmo_resp", {cpu_rvalid, cpu_err, cpu_rdata},
        {2'b11, 32'hFFFF_FFFF});
    chk("tmo_ren_low", pic_ren, 0);
    tick();
    chk("tmo_err_pulse", {cpu_err, cpu_rvalid}, 0);
`else
    repeat (300) tick();
    chk("hold_ren", {pic_ren, cpu_err, cpu_rvalid}, 3'b100);
    rq.push_back({1'b0, 32'hCAFE_F00D});
    pic_ready = 1'b1;
    tick();
    chk("hold_resp", {cpu_rvalid, cpu_err, cpu_rdata},
        {2'b10, 32'hCAFE_F00D});
    tick();
`endif
    tick();

    // reset in the middle of WR with two entries queued
    pic_ready = 1'b0;
    wr_req(16'h0040, 32'hB0, w);
    wr_req(16'h0044, 32'hB1, w);
    wr_req(16'h0048, 32'hB2, w);
    chk("mid_wen", pic_wen, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_drop", {pic_wen, pic_address, pic_data_in}, 0);
    wq.delete();
    tick();
    tick();
    reset     = 1'b1;
    pic_ready = 1'b1;
    n0  = n_wr_done;
    cnt = 0;
    repeat (20) begin
      if (pic_wen) cnt++;
      tick();
    end
    chk("no_wen_after", cnt, 0);
    chk("no_wr_done", n_wr_done - n0, 0);

    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
